// File: rtl/wbuff_fill_load_ctrl_if.sv
// Stream input plus per-column weight-buffer and weight-register control bus.
// master = upstream source / buffer array side, slave = wbuff_fill_load_ctrl.
interface wbuff_fill_load_ctrl_if #(
    parameter int nb_pe_col    = 16,
    parameter int nb_taps      = 11,
    parameter int buffer_width = 16,
    parameter int buffer_depth = 72
);
    localparam int AW = $clog2(buffer_depth);

    logic [buffer_width-1:0]           s_data;
    logic                              s_valid;
    logic                              s_ready;
    logic [nb_pe_col*AW-1:0]           wAddr;
    logic [nb_pe_col*buffer_width-1:0] buffer_data_in;
    logic [nb_pe_col-1:0]              buffer_wEn_AH;
    logic [nb_pe_col*AW-1:0]           rAddr;
    logic [nb_pe_col-1:0]              buffer_rEn_AH;
    logic [nb_pe_col*nb_taps-1:0]      weight_load_en;
    logic                              clear_all_wregs;

    modport master (
        output s_data, s_valid,
        input  s_ready, wAddr, buffer_data_in, buffer_wEn_AH, rAddr,
               buffer_rEn_AH, weight_load_en, clear_all_wregs
    );

    modport slave (
        input  s_data, s_valid,
        output s_ready, wAddr, buffer_data_in, buffer_wEn_AH, rAddr,
               buffer_rEn_AH, weight_load_en, clear_all_wregs
    );
endinterface

// File: rtl/wbuff_fill_load_ctrl.sv
// Weight-buffer fill (round-robin stream distribution) and tap-load controller.
// Optional WBUFF_FILL_LOAD_CTRL_ERR_EN adds a sticky err output and rejects bad configs.
module wbuff_fill_load_ctrl #(
    parameter int nb_pe_col         = 16,
    parameter int nb_taps           = 11,
    parameter int buffer_width      = 16,
    parameter int buffer_depth      = 72,
    parameter int buffer_addr_width = $clog2(buffer_depth),
    parameter int tap_idx_width     = $clog2(nb_taps + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    wbuff_fill_load_ctrl_if.slave        bus,
    input  logic                         fill_start,
    input  logic [buffer_addr_width-1:0] cfg_wr_base,
    input  logic [buffer_addr_width:0]   cfg_words_per_col,
    input  logic                         load_start,
    input  logic [buffer_addr_width-1:0] cfg_rd_base,
    input  logic [tap_idx_width-1:0]     cfg_nb_taps,
    output logic                         busy,
    output logic                         done
`ifdef WBUFF_FILL_LOAD_CTRL_ERR_EN
    , output logic                       err
`endif
);
    localparam int AW = buffer_addr_width;
    localparam int TW = tap_idx_width;
    localparam int NB = nb_pe_col;
    localparam int NT = nb_taps;
    localparam int BW = buffer_width;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [AW+1:0] DEPTH_SUM = (AW+2)'(buffer_depth);
    localparam logic [CW-1:0] COL_LAST  = CW'(NB - 1);
    localparam logic [NB-1:0] COL0_HOT  = {{(NB-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {S_IDLE, S_FILL, S_CLR, S_LOAD, S_DRAIN} state_t;

    state_t            r_state;
    logic [AW-1:0]     r_wr_base;
    logic [AW:0]       r_words;
    logic [CW-1:0]     r_col;
    logic [AW:0]       r_off;
    logic [AW-1:0]     r_rd_base;
    logic [TW-1:0]     r_ntaps;
    logic [TW-1:0]     r_tap;
    logic              r_s_ready;
    logic [NB*AW-1:0]  r_waddr;
    logic [NB*BW-1:0]  r_wdata;
    logic [NB-1:0]     r_wen;
    logic [NB*AW-1:0]  r_raddr;
    logic [NB-1:0]     r_ren;
    logic [NB*NT-1:0]  r_wle;
    logic              r_clr;
    logic              r_busy;
    logic              r_done;

    logic w_hs;
    logic w_fill_ok;
    logic w_load_ok;

    assign w_hs = bus.s_valid & r_s_ready;

    // (base + offset) modulo the bank depth; both operands are below the depth.
    function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] base, input logic [AW:0] off);
        logic [AW+1:0] s;
        s = {2'b00, base} + {1'b0, off};
        if (s >= DEPTH_SUM) s = s - DEPTH_SUM;
        return s[AW-1:0];
    endfunction

    function automatic logic [NB*NT-1:0] tap_strobe(input logic [TW-1:0] t);
        logic [NB*NT-1:0] m;
        m = '0;
        for (int c = 0; c < NB; c++) m[c*NT + int'(t)] = 1'b1;
        return m;
    endfunction

`ifdef WBUFF_FILL_LOAD_CTRL_ERR_EN
    localparam logic [AW:0]   DEPTH_CFG = (AW+1)'(buffer_depth);
    localparam logic [TW-1:0] NT_CFG    = TW'(nb_taps);

    logic r_err;

    assign w_fill_ok = (cfg_words_per_col <= DEPTH_CFG);
    assign w_load_ok = (cfg_nb_taps <= NT_CFG);
    assign err       = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (((fill_start || load_start) && r_state != S_IDLE) ||
                     (r_state == S_IDLE && fill_start && !w_fill_ok) ||
                     (r_state == S_IDLE && load_start && !fill_start && !w_load_ok)) begin
            r_err <= 1'b1;
        end
    end
`else
    assign w_fill_ok = 1'b1;
    assign w_load_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the per-column address/data registers are reset as well, because every output must read 0 out of reset.
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_wr_base <= '0;
            r_words   <= '0;
            r_col     <= '0;
            r_off     <= '0;
            r_rd_base <= '0;
            r_ntaps   <= '0;
            r_tap     <= '0;
            r_s_ready <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_wen     <= '0;
            r_raddr   <= '0;
            r_ren     <= '0;
            r_wle     <= '0;
            r_clr     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_wen  <= '0;
            r_wle  <= '0;
            r_clr  <= 1'b0;
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (fill_start && w_fill_ok) begin
                        r_wr_base <= cfg_wr_base;
                        r_words   <= cfg_words_per_col;
                        r_col     <= '0;
                        r_off     <= '0;
                        if (cfg_words_per_col == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state   <= S_FILL;
                            r_s_ready <= 1'b1;
                            r_busy    <= 1'b1;
                        end
                    end else if (load_start && !fill_start && w_load_ok) begin
                        r_rd_base <= cfg_rd_base;
                        r_ntaps   <= cfg_nb_taps;
                        r_tap     <= '0;
                        if (cfg_nb_taps == '0) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= S_CLR;
                            r_clr   <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    if (w_hs) begin
                        r_wen                   <= COL0_HOT << r_col;
                        r_waddr[r_col*AW +: AW] <= wrap_add(r_wr_base, r_off);
                        r_wdata[r_col*BW +: BW] <= bus.s_data;
                        if (r_col == COL_LAST) begin
                            r_col <= '0;
                            if (r_off == r_words - 1'b1) begin
                                r_state   <= S_IDLE;
                                r_s_ready <= 1'b0;
                                r_busy    <= 1'b0;
                                r_done    <= 1'b1;
                            end else begin
                                r_off <= r_off + 1'b1;
                            end
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                S_CLR: begin
                    r_state <= S_LOAD;
                    r_ren   <= '1;
                    r_raddr <= {NB{r_rd_base}};
                end
                S_LOAD: begin
                    // Strobe trails the read of the same tap by the one-cycle bank latency.
                    r_wle <= tap_strobe(r_tap);
                    if (r_tap == r_ntaps - 1'b1) begin
                        r_state <= S_DRAIN;
                        r_ren   <= '0;
                        r_done  <= 1'b1;
                    end else begin
                        r_tap   <= r_tap + 1'b1;
                        r_raddr <= {NB{wrap_add(r_rd_base, (AW+1)'(r_tap) + 1'b1)}};
                    end
                end
                S_DRAIN: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.s_ready         = r_s_ready;
    assign bus.wAddr           = r_waddr;
    assign bus.buffer_data_in  = r_wdata;
    assign bus.buffer_wEn_AH   = r_wen;
    assign bus.rAddr           = r_raddr;
    assign bus.buffer_rEn_AH   = r_ren;
    assign bus.weight_load_en  = r_wle;
    assign bus.clear_all_wregs = r_clr;
    assign busy                = r_busy;
    assign done                = r_done;
endmodule

// File: tb/tb_wbuff_fill_load_ctrl.sv
// Self-checking bench for wbuff_fill_load_ctrl: directed fills/loads with random data,
// handshake gaps and configs, checked against a word-index-based reference model.
module tb_wbuff_fill_load_ctrl;
    localparam int NB    = 16;
    localparam int NT    = 11;
    localparam int BW    = 16;
    localparam int DEPTH = 72;
    localparam int AW    = 7;
    localparam int TW    = 4;

    logic          clk;
    logic          rst_n;
    logic          fill_start;
    logic [AW-1:0] cfg_wr_base;
    logic [AW:0]   cfg_words_per_col;
    logic          load_start;
    logic [AW-1:0] cfg_rd_base;
    logic [TW-1:0] cfg_nb_taps;
    logic          busy;
    logic          done;
`ifdef WBUFF_FILL_LOAD_CTRL_ERR_EN
    logic          err;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: last written address/data per column.
    int          exp_waddr [NB];
    logic [15:0] exp_wdata [NB];

    wbuff_fill_load_ctrl_if #(.nb_pe_col(NB), .nb_taps(NT), .buffer_width(BW), .buffer_depth(DEPTH)) bus ();

    wbuff_fill_load_ctrl #(
        .nb_pe_col(NB), .nb_taps(NT), .buffer_width(BW), .buffer_depth(DEPTH)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .bus               (bus.slave),
        .fill_start        (fill_start),
        .cfg_wr_base       (cfg_wr_base),
        .cfg_words_per_col (cfg_words_per_col),
        .load_start        (load_start),
        .cfg_rd_base       (cfg_rd_base),
        .cfg_nb_taps       (cfg_nb_taps),
        .busy              (busy),
        .done              (done)
`ifdef WBUFF_FILL_LOAD_CTRL_ERR_EN
        , .err             (err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [NB*AW-1:0] model_waddr();
        logic [NB*AW-1:0] v;
        for (int c = 0; c < NB; c++) v[c*AW +: AW] = AW'(exp_waddr[c]);
        return v;
    endfunction

    function automatic logic [NB*BW-1:0] model_wdata();
        logic [NB*BW-1:0] v;
        for (int c = 0; c < NB; c++) v[c*BW +: BW] = exp_wdata[c];
        return v;
    endfunction

    function automatic logic [NB*AW-1:0] all_cols_addr(input int a);
        logic [NB*AW-1:0] v;
        for (int c = 0; c < NB; c++) v[c*AW +: AW] = AW'(a % DEPTH);
        return v;
    endfunction

    // Bit i belongs to tap (i mod NT) of column (i / NT).
    function automatic logic [NB*NT-1:0] strobe_for_tap(input int t);
        logic [NB*NT-1:0] v;
        for (int i = 0; i < NB*NT; i++) v[i] = ((i % NT) == t);
        return v;
    endfunction

    task automatic model_clear();
        for (int c = 0; c < NB; c++) begin
            exp_waddr[c] = 0;
            exp_wdata[c] = '0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wen"},   bus.buffer_wEn_AH, '0);
        check({tag, "_waddr"}, bus.wAddr, '0);
        check({tag, "_wdata"}, bus.buffer_data_in, '0);
        check({tag, "_ren"},   bus.buffer_rEn_AH, '0);
        check({tag, "_raddr"}, bus.rAddr, '0);
        check({tag, "_wle"},   bus.weight_load_en, '0);
        check({tag, "_ctl"},   {bus.s_ready, bus.clear_all_wregs, busy, done}, '0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_clear();
        check_all_zero("rst");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    // vmode: 0 = s_valid constant, 1 = toggled 1/0, 2 = random.
    task automatic do_fill(input int base, input int words, input int vmode,
                           input bit with_load, input bit stray, input bit seq_data);
        int total, k, cyc, col;
        bit hs;
        logic [15:0] d;
        logic [NB-1:0] exp_wen;
        total = words * NB;
        k = 0;
        cyc = 0;
        col = 0;
        cfg_wr_base       = AW'(base);
        cfg_words_per_col = (AW+1)'(words);
        cfg_nb_taps       = 4'd3;
        cfg_rd_base       = '0;
        fill_start        = 1'b1;
        load_start        = with_load;
        tick();
        fill_start = 1'b0;
        load_start = 1'b0;
        check("fill_start_busy", {busy, bus.s_ready, done}, 3'b110);
        while (k < total && cyc < 4000) begin
            case (vmode)
                0:       bus.s_valid = 1'b1;
                1:       bus.s_valid = (cyc % 2 == 0);
                default: bus.s_valid = 1'($urandom_range(0, 1));
            endcase
            d = seq_data ? 16'(16'h100 + k) : 16'($urandom);
            bus.s_data = d;
            fill_start = stray && (cyc == 2);
            load_start = stray && (cyc == 2);
            hs = bus.s_valid;
            check("fill_ready", bus.s_ready, 1'b1);
            tick();
            fill_start = 1'b0;
            load_start = 1'b0;
            exp_wen = '0;
            if (hs) begin
                col = k % NB;
                exp_waddr[col] = (base + k / NB) % DEPTH;
                exp_wdata[col] = d;
                exp_wen[col]   = 1'b1;
                k++;
            end
            check("fill_wen",   bus.buffer_wEn_AH, exp_wen);
            check("fill_waddr", bus.wAddr, model_waddr());
            check("fill_wdata", bus.buffer_data_in, model_wdata());
            check("fill_done",  done, (hs && k == total));
            check("fill_noload", {bus.clear_all_wregs, bus.buffer_rEn_AH}, '0);
            cyc++;
        end
        check("fill_all_words", 32'(k), 32'(total));
        bus.s_valid = 1'b0;
        check("fill_end_state", {busy, bus.s_ready}, 2'b00);
        tick();
        check("fill_post", {busy, bus.s_ready, done, bus.clear_all_wregs}, 4'b0000);
        check("fill_post_wen", bus.buffer_wEn_AH, '0);
    endtask

    task automatic do_load(input int base, input int n);
        cfg_rd_base = AW'(base);
        cfg_nb_taps = TW'(n);
        load_start  = 1'b1;
        tick();
        load_start = 1'b0;
        check("load_clr", {bus.clear_all_wregs, busy, done}, 3'b110);
        check("load_clr_quiet", {bus.buffer_rEn_AH, bus.weight_load_en}, '0);
        for (int t = 0; t < n; t++) begin
            tick();
            check("load_ren",   bus.buffer_rEn_AH, {NB{1'b1}});
            check("load_raddr", bus.rAddr, all_cols_addr(base + t));
            check("load_wle",   bus.weight_load_en, (t == 0) ? '0 : strobe_for_tap(t - 1));
            check("load_ctl",   {bus.clear_all_wregs, busy, done}, 3'b010);
        end
        tick();
        check("drain_ren",  bus.buffer_rEn_AH, '0);
        check("drain_wle",  bus.weight_load_en, strobe_for_tap(n - 1));
        check("drain_done", {busy, done}, 2'b11);
        tick();
        check("load_post", {busy, done, bus.clear_all_wregs}, 3'b000);
        check("load_post_wle", bus.weight_load_en, '0);
    endtask

    initial begin
        rst_n             = 1'b0;
        fill_start        = 1'b0;
        load_start        = 1'b0;
        cfg_wr_base       = '0;
        cfg_words_per_col = '0;
        cfg_rd_base       = '0;
        cfg_nb_taps       = '0;
        bus.s_valid       = 1'b0;
        bus.s_data        = '0;
        model_clear();
        #12;
        check_all_zero("reset");
`ifdef WBUFF_FILL_LOAD_CTRL_ERR_EN
        check("reset_err", err, 1'b0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Abort a fill after 5 handshakes with an asynchronous reset.
        cfg_wr_base       = '0;
        cfg_words_per_col = 8'd2;
        fill_start        = 1'b1;
        tick();
        fill_start  = 1'b0;
        bus.s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.s_data = 16'(16'h0AA0 + i);
            tick();
        end
        bus.s_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        check_all_zero("abort");
        tick();
        rst_n = 1'b1;
        tick();
        check("abort_no_done", {done, busy}, 2'b00);
        tick();
        check("abort_no_done2", {done, busy}, 2'b00);

        do_fill(0, 2, 0, 1'b0, 1'b0, 1'b1);
        do_fill(70, 3, 0, 1'b0, 1'b0, 1'b0);
        do_fill(5, 2, 1, 1'b0, 1'b0, 1'b0);
        do_fill(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 4)), 2, 1'b0, 1'b1, 1'b0);

        do_load(4, 11);
        do_load(68, int'($urandom_range(5, 11)));
        do_load(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(1, 11)));

        // Simultaneous starts: fill wins, load dropped.
        do_fill(int'($urandom_range(0, DEPTH - 1)), 1, 2, 1'b1, 1'b0, 1'b0);
        tick();
        check("dropped_load", {bus.clear_all_wregs, busy, bus.buffer_rEn_AH}, '0);

        // Zero-length fill and load complete at once.
        cfg_words_per_col = '0;
        fill_start        = 1'b1;
        tick();
        fill_start = 1'b0;
        check("zero_fill", {done, busy, bus.s_ready}, 3'b100);
        check("zero_fill_wen", bus.buffer_wEn_AH, '0);
        tick();
        check("zero_fill_post", {done, busy}, 2'b00);
        cfg_nb_taps = '0;
        load_start  = 1'b1;
        tick();
        load_start = 1'b0;
        check("zero_load", {done, busy, bus.clear_all_wregs}, 3'b100);
        check("zero_load_ren", bus.buffer_rEn_AH, '0);
        tick();
        check("zero_load_post", {done, busy, bus.clear_all_wregs}, 3'b000);

`ifdef WBUFF_FILL_LOAD_CTRL_ERR_EN
        do_reset();
        check("err_clean", err, 1'b0);
        cfg_nb_taps = 4'd12;
        load_start  = 1'b1;
        tick();
        load_start = 1'b0;
        check("err_taps", {err, busy, bus.clear_all_wregs}, 3'b100);
        tick();
        check("err_taps_idle", {busy, bus.clear_all_wregs, done}, 3'b000);
        do_reset();
        cfg_words_per_col = 8'd73;
        fill_start        = 1'b1;
        tick();
        fill_start = 1'b0;
        check("err_words", {err, busy, bus.s_ready}, 3'b100);
        do_reset();
        cfg_words_per_col = 8'd1;
        fill_start        = 1'b1;
        tick();
        check("err_busy_pre", {err, busy}, 2'b01);
        tick();
        fill_start = 1'b0;
        check("err_busy", err, 1'b1);
        do_reset();
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/wbuff_fill_load_ctrl.md
Name: wbuff_fill_load_ctrl

Overview:
- Controller directly upstream of the per-column weight buffer array.
- Fill phase: accepts a weight-word stream over a valid/ready handshake and distributes it round-robin into the nb_pe_col buffer banks. Drives per-column write address, data and active-high write enable.
- Load phase: reads nb_taps_used consecutive words from every bank in parallel and pulses the matching weight_load_en tap bits, so the weight registers are loaded one tap per cycle.

Parameters:
- nb_pe_col, 16, number of PE columns / buffer banks
- nb_taps, 11, maximum weight taps per column
- buffer_width, 16, buffer word width
- buffer_depth, 72, words per bank
- buffer_addr_width, clogb2(buffer_depth), bank address width (7 at default)
- tap_idx_width, clogb2(nb_taps+1), width of tap counts (4 at default)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- s_data  in  buffer_width  incoming weight word
- s_valid  in  1  s_data valid
- s_ready  out  1  controller accepts s_data
- fill_start  in  1  single-cycle pulse; begins fill
- cfg_wr_base  in  buffer_addr_width  first write address
- cfg_words_per_col  in  buffer_addr_width+1  words per column to fill (1..buffer_depth)
- load_start  in  1  single-cycle pulse; begins load
- cfg_rd_base  in  buffer_addr_width  first read address
- cfg_nb_taps  in  tap_idx_width  taps to load (1..nb_taps)
- wAddr  out  nb_pe_col*buffer_addr_width  per-column write address
- buffer_data_in  out  nb_pe_col*buffer_width  per-column write data
- buffer_wEn_AH  out  nb_pe_col  per-column write enable, active high
- rAddr  out  nb_pe_col*buffer_addr_width  per-column read address (all equal)
- buffer_rEn_AH  out  nb_pe_col  per-column read enable, active high
- weight_load_en  out  nb_pe_col*nb_taps  per-column, per-tap load strobe
- clear_all_wregs  out  1  clears weight registers
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse at the end of fill or load

Behaviour:
- Reset: every output is 0 and the state is IDLE. An asynchronous reset mid-operation aborts it; no done pulse follows.
- States: IDLE, FILL, CLR, LOAD, DRAIN.
- IDLE:
  - fill_start -> FILL: latch cfg_wr_base and cfg_words_per_col, zero column index c and word offset a.
  - load_start -> CLR: latch cfg_rd_base and cfg_nb_taps.
  - If both are asserted in the same cycle, fill_start wins and load_start is dropped.
  - Starts are ignored outside IDLE.
- FILL:
  - s_ready = 1.
  - On each handshake (s_valid & s_ready), the next cycle drives buffer_wEn_AH one-hot at bit c, wAddr[c] = (base+a) mod buffer_depth, buffer_data_in[c] = s_data. Other columns hold their previous addr/data. Write latency is 1 cycle.
  - c increments each handshake. At c = nb_pe_col-1, c wraps to 0 and a increments.
  - The handshake that completes a = words_per_col-1, c = nb_pe_col-1 deasserts s_ready in the same cycle via the registered state -> IDLE. That final write issues in the next cycle, together with done.
  - Address wrap: base+a ≥ buffer_depth wraps to base+a-buffer_depth (71 -> 0).
- CLR: clear_all_wregs = 1 for exactly one cycle -> LOAD.
- LOAD:
  - For tap counter t = 0..cfg_nb_taps-1, one per cycle: buffer_rEn_AH = all ones, rAddr[*] = (rd_base+t) mod buffer_depth.
  - After issuing t = cfg_nb_taps-1 -> DRAIN.
- Load strobe:
  - weight_load_en[col][t] = 1 for all cols exactly one cycle after the read of tap t (bank read latency 1 cycle). All other tap bits are 0.
- DRAIN: one cycle carrying the last load strobe; done = 1 in this cycle -> IDLE.
- cfg_words_per_col = 0 or cfg_nb_taps = 0: the start completes immediately. Next cycle: done = 1, state IDLE, no writes, reads or clear.

Optional Feature:
- Macro: WBUFF_FILL_LOAD_CTRL_ERR_EN.
- When defined: adds output err (1 bit, sticky until reset). err is set when:
  - a start pulse arrives while busy,
  - cfg_words_per_col > buffer_depth,
  - cfg_nb_taps > nb_taps.
- Out-of-range configs with the macro defined: the start is rejected and the state stays IDLE.
- When undefined: no err port; an out-of-range configuration gives undefined behaviour.

Test Plan:
- Reset mid-FILL after 5 handshakes -> all outputs 0 immediately. No done pulse. A fresh fill then starts at c = 0.
- fill_start, base = 0, words_per_col = 2, 32 words 0x100..0x11F with s_valid constant -> column k%16 written with 0x100+k at addr k/16. Each write is 1 cycle after its handshake. done fires with the last write. s_ready stays low afterwards.
- Fill with base = 70, words_per_col = 3 -> addresses 70, 71, 0 per column.
- Fill with s_valid toggled 1/0 -> writes occur only after handshakes; ordering is unchanged.
- load_start, rd_base = 4, nb_taps = 11 -> clear_all_wregs for 1 cycle, then rAddr 4..14 on consecutive cycles. weight_load_en tap t is high for all columns in the cycle after the read of tap t. done coincides with tap 10.
- fill_start and load_start in the same cycle -> fill executes and the load is ignored. With the macro defined: cfg_nb_taps = 12 -> err = 1, state stays IDLE.
